// File: rtl/set_dispatch.sv
// set_dispatch: job FIFO and issue FSM feeding the SET candidate engine.
// Define SET_DISPATCH_TIMEOUT_EN to build the WAIT-state timeout path.
module set_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 6,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             job_valid,
    output logic             job_ready,
    input  logic [23:0]      job_central,
    input  logic [11:0]      job_radius,
    input  logic [1:0]       job_mode,
    input  logic [TAG_W-1:0] job_tag,
    input  logic             set_busy,
    input  logic             set_valid,
    input  logic [7:0]       set_candidate,
    output logic             set_en,
    output logic [23:0]      set_central,
    output logic [11:0]      set_radius,
    output logic [1:0]       set_mode,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_candidate,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_timeout,
    output logic             idle
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [23:0]      central;
        logic [11:0]      radius;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
    } job_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    job_t             mem_q [DEPTH];
    job_t             job_in;
    job_t             head;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop, empty;
    logic             tmo_hit;

    state_t           state_q, state_d;
    logic             set_en_q, set_en_d;
    logic [23:0]      set_central_q, set_central_d;
    logic [11:0]      set_radius_q, set_radius_d;
    logic [1:0]       set_mode_q, set_mode_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             res_valid_q, res_valid_d;
    logic [7:0]       res_candidate_q, res_candidate_d;
    logic [TAG_W-1:0] res_tag_q, res_tag_d;

    assign job_in    = {job_central, job_radius, job_mode, job_tag};
    assign head      = mem_q[rptr_q];
    assign empty     = (count_q == '0);
    assign job_ready = (count_q != FULL_CNT);
    assign push      = job_valid && job_ready;
    assign pop       = (state_q == IDLE) && !empty && !set_busy;
    assign idle      = empty && (state_q == IDLE);

    assign set_en        = set_en_q;
    assign set_central   = set_central_q;
    assign set_radius    = set_radius_q;
    assign set_mode      = set_mode_q;
    assign res_valid     = res_valid_q;
    assign res_candidate = res_candidate_q;
    assign res_tag       = res_tag_q;

    always_comb begin
        wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    // Storage needs no reset: a cleared count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= job_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

`ifdef SET_DISPATCH_TIMEOUT_EN
    localparam logic [15:0] TMO = 16'(TIMEOUT);

    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic        res_timeout_q, res_timeout_d;

    assign cnt_inc     = (cnt_q == TMO) ? cnt_q : cnt_q + 16'd1;
    assign tmo_hit     = (state_q == WAIT) && (cnt_inc == TMO);
    assign res_timeout = res_timeout_q;

    always_comb begin
        cnt_d         = cnt_q;
        res_timeout_d = res_timeout_q;
        if (state_q == ISSUE) begin
            cnt_d = '0;
        end else if (state_q == WAIT) begin
            cnt_d = cnt_inc;
            if (set_valid) begin
                res_timeout_d = 1'b0;
            end else if (tmo_hit) begin
                res_timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            res_timeout_q <= res_timeout_d;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign res_timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        set_en_d        = 1'b0;
        set_central_d   = set_central_q;
        set_radius_d    = set_radius_q;
        set_mode_d      = set_mode_q;
        tag_d           = tag_q;
        res_valid_d     = res_valid_q;
        res_candidate_d = res_candidate_q;
        res_tag_d       = res_tag_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d       = ISSUE;
                    set_en_d      = 1'b1;
                    set_central_d = head.central;
                    set_radius_d  = head.radius;
                    set_mode_d    = head.mode;
                    tag_d         = head.tag;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                // A result arriving on the timeout cycle takes priority.
                if (set_valid) begin
                    state_d         = HOLD;
                    res_valid_d     = 1'b1;
                    res_candidate_d = set_candidate;
                    res_tag_d       = tag_q;
                end else if (tmo_hit) begin
                    state_d         = HOLD;
                    res_valid_d     = 1'b1;
                    res_candidate_d = '0;
                    res_tag_d       = tag_q;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            set_en_q        <= 1'b0;
            set_central_q   <= '0;
            set_radius_q    <= '0;
            set_mode_q      <= '0;
            tag_q           <= '0;
            res_valid_q     <= 1'b0;
            res_candidate_q <= '0;
            res_tag_q       <= '0;
        end else begin
            state_q         <= state_d;
            set_en_q        <= set_en_d;
            set_central_q   <= set_central_d;
            set_radius_q    <= set_radius_d;
            set_mode_q      <= set_mode_d;
            tag_q           <= tag_d;
            res_valid_q     <= res_valid_d;
            res_candidate_q <= res_candidate_d;
            res_tag_q       <= res_tag_d;
        end
    end

endmodule

// File: tb/tb_set_dispatch.sv
// tb_set_dispatch: directed table-driven bench for set_dispatch
// with a behavioural SET engine model.
module tb_set_dispatch;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 6;
    localparam int TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [23:0]      job_central = '0;
    logic [11:0]      job_radius = '0;
    logic [1:0]       job_mode = '0;
    logic [TAG_W-1:0] job_tag = '0;
    logic             set_busy;
    logic             set_valid = 1'b0;
    logic [7:0]       set_candidate = '0;
    logic             set_en;
    logic [23:0]      set_central;
    logic [11:0]      set_radius;
    logic [1:0]       set_mode;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [7:0]       res_candidate;
    logic [TAG_W-1:0] res_tag;
    logic             res_timeout;
    logic             idle;

    always #5 clk = ~clk;

    set_dispatch #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_central(job_central),
        .job_radius(job_radius),
        .job_mode(job_mode),
        .job_tag(job_tag),
        .set_busy(set_busy),
        .set_valid(set_valid),
        .set_candidate(set_candidate),
        .set_en(set_en),
        .set_central(set_central),
        .set_radius(set_radius),
        .set_mode(set_mode),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_candidate(res_candidate),
        .res_tag(res_tag),
        .res_timeout(res_timeout),
        .idle(idle)
    );

    typedef struct {
        logic [23:0]      central;
        logic [11:0]      radius;
        logic [1:0]       mode;
        logic [TAG_W-1:0] tag;
        logic [7:0]       cand;
    } vec_t;

    vec_t vt [6];
    int   passed = 0;
    int   total = 0;

    // Behavioural SET: result = central[6:0], lat negedges after en.
    logic busy_force = 1'b0;
    logic hang = 1'b0;
    logic act = 1'b0;
    logic en_prev = 1'b0;
    int   cd = 0;
    int   lat = 3;
    int   en_cnt = 0;
    int   en_long = 0;

    assign set_busy = busy_force | act;

    always @(negedge clk) begin
        set_valid = 1'b0;
        if (set_en) en_cnt++;
        if (set_en && en_prev) en_long++;
        en_prev = set_en;
        if (!rst) begin
            act = 1'b0;
        end else if (act) begin
            cd--;
            if (cd == 0) begin
                act = 1'b0;
                if (!hang) begin
                    set_valid = 1'b1;
                    set_candidate = {1'b0, set_central[6:0]};
                end
            end
        end else if (set_en) begin
            act = 1'b1;
            cd = lat;
        end
    end

    task automatic check(input string name, input logic [31:0] act_v,
                         input logic [31:0] exp_v);
        total++;
        if (act_v === exp_v) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
    endtask

    task automatic drive(input int i);
        job_central = vt[i].central;
        job_radius  = vt[i].radius;
        job_mode    = vt[i].mode;
        job_tag     = vt[i].tag;
    endtask

    task automatic push(input int i);
        @(negedge clk);
        drive(i);
        job_valid = 1'b1;
        check($sformatf("push%0d ready", i), 32'(job_ready), 32'd1);
        @(posedge clk);
        #1 job_valid = 1'b0;
    endtask

    task automatic collect(input string name, input int i, input logic to);
        int n = 0;
        logic [7:0] c;
        c = to ? 8'h00 : vt[i].cand;
        @(negedge clk);
        while (!res_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid"}, 32'(res_valid), 32'd1);
        check({name, " cand"}, 32'(res_candidate), 32'(c));
        check({name, " tag"}, 32'(res_tag), 32'(vt[i].tag));
        check({name, " tmo"}, 32'(res_timeout), 32'(to));
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e;
        int k;
        int unstable;

        vt[0] = '{24'h12340C, 12'h321, 2'b00, 6'd5, 8'h0C};
        vt[1] = '{24'h45A721, 12'h9F0, 2'b01, 6'd0, 8'h21};
        vt[2] = '{24'h9BC340, 12'h555, 2'b10, 6'd1, 8'h40};
        vt[3] = '{24'h777F3F, 12'hABC, 2'b11, 6'd2, 8'h3F};
        vt[4] = '{24'hABC881, 12'h012, 2'b00, 6'd3, 8'h01};
        vt[5] = '{24'hFEDC00, 12'hFFF, 2'b01, 6'd4, 8'h00};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst set_en", 32'(set_en), 32'd0);
        check("rst set_central", 32'(set_central), 32'd0);
        check("rst set_radius", 32'(set_radius), 32'd0);
        check("rst set_mode", 32'(set_mode), 32'd0);
        check("rst res_valid", 32'(res_valid), 32'd0);
        check("rst res_cand", 32'(res_candidate), 32'd0);
        check("rst res_tag", 32'(res_tag), 32'd0);
        check("rst res_tmo", 32'(res_timeout), 32'd0);
        check("rst job_ready", 32'(job_ready), 32'd1);
        check("rst idle", 32'(idle), 32'd1);
        rst = 1'b1;

        // Single job with issue timing
        e = en_cnt;
        en_long = 0;
        push(0);
        @(negedge clk);
        check("t1 en early", 32'(set_en), 32'd0);
        @(negedge clk);
        check("t1 en timing", 32'(set_en), 32'd1);
        check("t1 central", 32'(set_central), 32'(vt[0].central));
        check("t1 radius", 32'(set_radius), 32'(vt[0].radius));
        check("t1 mode", 32'(set_mode), 32'(vt[0].mode));
        collect("t1", 0, 1'b0);
        @(negedge clk);
        check("t1 en count", 32'(en_cnt - e), 32'd1);
        check("t1 en width", 32'(en_long), 32'd0);
        check("t1 idle", 32'(idle), 32'd1);
        check("t1 held central", 32'(set_central), 32'(vt[0].central));

        // Five jobs into a 4-deep FIFO while SET is busy
        busy_force = 1'b1;
        e = en_cnt;
        for (int i = 1; i <= 4; i++) push(i);
        @(negedge clk);
        check("t2 full", 32'(job_ready), 32'd0);
        check("t2 no issue", 32'(en_cnt - e), 32'd0);
        busy_force = 1'b0;
        n = 0;
        while (!job_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        push(5);
        for (int i = 1; i <= 5; i++) collect($sformatf("t2 r%0d", i), i, 1'b0);

        // Result held with res_ready low for 10 cycles
        push(0);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        e = en_cnt;
        unstable = 0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || res_candidate !== vt[0].cand ||
                res_tag !== vt[0].tag || res_timeout !== 1'b0)
                unstable++;
            if (j < 4) begin
                check($sformatf("t3 accept%0d", j), 32'(job_ready), 32'd1);
                drive(j + 1);
                job_valid = 1'b1;
            end else begin
                if (j == 4) check("t3 full", 32'(job_ready), 32'd0);
                job_valid = 1'b0;
            end
        end
        check("t3 stable", 32'(unstable), 32'd0);
        check("t3 no issue", 32'(en_cnt - e), 32'd0);
        for (int i = 0; i <= 4; i++) collect($sformatf("t3 r%0d", i), i, 1'b0);

`ifdef SET_DISPATCH_TIMEOUT_EN
        // Hung SET: timeout result, then a normal job
        hang = 1'b1;
        push(3);
        n = 0;
        while (!set_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!res_valid && k < 40);
        check("t4 tmo latency", 32'(k), 32'd9);
        collect("t4 tmo", 3, 1'b1);
        hang = 1'b0;
        push(4);
        collect("t4 next", 4, 1'b0);
`endif

        // Reset mid-WAIT with two jobs queued
        lat = 30;
        push(1);
        push(2);
        push(3);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("t5 set_en", 32'(set_en), 32'd0);
        check("t5 res_valid", 32'(res_valid), 32'd0);
        check("t5 res_tmo", 32'(res_timeout), 32'd0);
        check("t5 central", 32'(set_central), 32'd0);
        check("t5 radius", 32'(set_radius), 32'd0);
        check("t5 job_ready", 32'(job_ready), 32'd1);
        check("t5 idle", 32'(idle), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        lat = 3;
        e = en_cnt;
        repeat (8) @(negedge clk);
        check("t5 post idle", 32'(idle), 32'd1);
        check("t5 post no en", 32'(en_cnt - e), 32'd0);

        // Push and pop on the same edge at count 2, then wrap pointers
        busy_force = 1'b1;
        push(1);
        push(2);
        @(negedge clk);
        busy_force = 1'b0;
        drive(3);
        job_valid = 1'b1;
        check("t6 ready", 32'(job_ready), 32'd1);
        @(posedge clk);
        #1 job_valid = 1'b0;
        @(negedge clk);
        check("t6 pop data", 32'(set_central), 32'(vt[1].central));
        check("t6 issue", 32'(set_en), 32'd1);
        push(4);
        push(5);
        @(negedge clk);
        check("t6 count", 32'(job_ready), 32'd0);
        for (int i = 1; i <= 5; i++) collect($sformatf("t6 r%0d", i), i, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/set_dispatch.md
# set_dispatch

Upstream feeder for the `SET` candidate-counting engine. It queues set-geometry jobs (central, radius, mode, tag) in a small FIFO and issues them one at a time to `SET` through its `en`/`busy` interface. It then captures `candidate` on `valid` and returns each result, tagged, through a valid/ready result port. It replaces bench-style driving of `SET` so a host or DMA can stream the 64-pattern set without cycle-accurate control.

## Interface
- `DEPTH`, 4: job FIFO entries; power of two, ≥2.
- `TAG_W`, 6: job tag width.
- `TIMEOUT`, 1023: maximum cycles spent in WAIT before abandoning a job; range 1..65535.

Clocking and reset: one clock; reset is asynchronous and active-low.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `job_valid`  in  1  job offered.
- `job_ready`  out  1  FIFO can accept (`!full`).
- `job_central`  in  24  {x1,y1,x2,y2,x3,y3}, 4 bits each.
- `job_radius`  in  12  {r1,r2,r3}, 4 bits each.
- `job_mode`  in  2  00 A, 01 A∪B, 10 A⊕B, 11 intersect.
- `job_tag`  in  TAG_W  returned with the result.
- `set_busy`  in  1  `SET` busy.
- `set_valid`  in  1  `SET` result valid.
- `set_candidate`  in  8  `SET` result.
- `set_en`  out  1  one-cycle issue pulse.
- `set_central`  out  24  registered; held between issues.
- `set_radius`  out  12  registered; held.
- `set_mode`  out  2  registered; held.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts.
- `res_candidate`  out  8  captured count.
- `res_tag`  out  TAG_W  tag of the job.
- `res_timeout`  out  1  job abandoned by the timeout.
- `idle`  out  1  FIFO empty and FSM in IDLE.

## Operation
- FIFO push happens on `job_valid && job_ready`. Pop happens on the IDLE→ISSUE transition. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH. A count of log2(DEPTH)+1 bits distinguishes full from empty.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - If the FIFO is non-empty and `set_busy==0`, go to ISSUE.
  - On that edge, load the FIFO head into `set_central`, `set_radius`, `set_mode` and an internal tag register.
- ISSUE (exactly 1 cycle):
  - `set_en=1`.
  - `set_valid` is ignored in this cycle.
  - Go to WAIT and clear the timeout counter.
- WAIT:
  - On `set_valid==1`, capture `set_candidate` into `res_candidate`, set `res_timeout=0`, and go to HOLD.
  - Otherwise increment the counter.
  - If the counter reaches TIMEOUT, set `res_candidate=0` and `res_timeout=1`, then go to HOLD.
  - A `set_valid` in the same cycle as the counter reaching TIMEOUT wins: a normal result is captured.
- HOLD:
  - `res_valid=1`. `res_candidate`, `res_tag` and `res_timeout` are stable until `res_ready` is sampled high.
  - Then go to IDLE.
- `set_*` data outputs are never changed except on IDLE→ISSUE. Only one job is outstanding at `SET` at any time.
- Arithmetic:
  - The counter is 16 bits and saturates at TIMEOUT.
  - `res_candidate` is passed through unmodified, range 0..64.
- Reset (asserted at any time, including mid-WAIT):
  - All FIFO entries are discarded and the FSM returns to IDLE.
  - `set_en`, `res_valid` and `res_timeout` go to 0 immediately (asynchronously).
- Reset values: `set_en=0`, `set_central=0`, `set_radius=0`, `set_mode=0`, `res_valid=0`, `res_candidate=0`, `res_tag=0`, `res_timeout=0`, `job_ready=1`, `idle=1`.

## Timing
- Job accepted at edge N into an empty FIFO, with FSM in IDLE and `set_busy` low: IDLE→ISSUE at edge N+1, so `set_en` is high in cycle N+1 to N+2.
- If `set_busy` is high, the issue is deferred cycle by cycle until it is sampled low.
- `set_valid` sampled high at edge M: `res_valid` is high from edge M onward, giving 1 cycle of latency.
- Result handshake completes at edge H: back in IDLE after H. The earliest next `set_en` is in the cycle after edge H+1.
- Back-to-back throughput is therefore SET latency + 3 cycles per job.
- `job_ready` is combinational from the registered count and does not depend on `job_valid`.

## Configuration
- `SET_DISPATCH_TIMEOUT_EN` defined: the timeout counter and the `res_timeout` path are built as described above.
- `SET_DISPATCH_TIMEOUT_EN` undefined:
  - No counter is built and `res_timeout` is tied to 0.
  - WAIT leaves only on `set_valid`, so a hung `SET` stalls the block until reset.
  - The `TIMEOUT` parameter is unused.

## Test plan
- Single job, mode 00, tag 5, with a behavioural `SET` returning 0x0C 3 cycles after `en`. Required: exactly one 1-cycle `set_en`; `res_valid` with `res_candidate=0x0C`, `res_tag=5`, `res_timeout=0`; then `idle=1`.
- Push 5 jobs back-to-back with DEPTH=4 while `set_busy=1`. Required: `job_ready` drops after the 4th push (the 5th is stalled); after `busy` is released, the results come back in tag order 0..4.
- Hold `res_ready=0` for 10 cycles. Required: `res_*` stable for all 10 cycles, no new `set_en`, and FIFO pushes still accepted until full.
- `SET` never asserts `valid`, TIMEOUT=8, macro defined. Required: `res_timeout=1` and `res_candidate=0` 9 cycles after ISSUE, and the next job then issues normally.
- Assert `rst` low mid-WAIT with 2 jobs queued. Required: outputs go to their reset values immediately, and after release `idle=1` with no `set_en`.
- Simultaneous push and pop with count=2. Required: count stays 2 and the pointer wrap past DEPTH-1 returns correct data.
